adc_sample_pattern_gen: RTL and testbench

ADC_SAMPLE_PATTERN_GEN -- requirements
Module: adc_sample_pattern_gen

---
 rtl/adc_sim_pkg.sv | 41 ++++
 rtl/adc_pn9_lfsr.sv | 24 ++
 rtl/adc_sample_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_adc_sample_pattern_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sim_pkg.sv
// Shared types and constants for the ADC sample pattern generator.
package adc_sim_pkg;

  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 14;

  typedef logic [VEC_W-1:0] adc_word_t;

  typedef enum logic [3:0] {
    TM_NORMAL   = 4'd0,
    TM_MIDSCALE = 4'd1,
    TM_POS_FS   = 4'd2,
    TM_NEG_FS   = 4'd3,
    TM_CHECKER  = 4'd4,
    TM_TOGGLE   = 4'd5,
    TM_PN9      = 4'd6,
    TM_RAMP     = 4'd7
  } test_mode_e;

  localparam adc_word_t MIDSCALE_TC = 14'h0000;
  localparam adc_word_t POS_FS_TC   = 14'h1FFF;
  localparam adc_word_t NEG_FS_TC   = 14'h2000;
  localparam adc_word_t CHECKER_A   = 14'h2AAA;
  localparam adc_word_t CHECKER_B   = 14'h1555;
  localparam adc_word_t TOGGLE_HI   = 14'h3FFF;
  // XOR mask turning a two's-complement word into offset binary
  localparam adc_word_t FMT_MSB     = 14'h2000;
  localparam logic [8:0] PN9_SEED   = 9'h1FF;

  // x^9 + x^5 + 1, shifting toward the MSB
  function automatic logic [8:0] pn9_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  // One pipeline stage payload for both channels (lane 0 = A, lane 1 = B)
  typedef struct packed {
    adc_word_t [NUM_LANES-1:0] data;
    logic [NUM_LANES-1:0]      ovr;
  } lane_pkt_t;

endpackage

// File: rtl/adc_pn9_lfsr.sv
// PN9 generator state. reseed loads the seed in the same cycle, so a
// reseed with advance set lands one step past the seed.
module adc_pn9_lfsr
  import adc_sim_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       reseed,
  output logic [8:0] state
);

  logic [8:0] base;

  assign base = reseed ? PN9_SEED : state;

  // LFSR register: hold, reseed, or step from the (possibly reseeded) base
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        state <= PN9_SEED;
    else if (advance) state <= pn9_step(base);
    else              state <= base;
  end

endmodule

// File: rtl/adc_sample_pattern_gen.sv
// Dual-channel ADC sample / test-pattern generator with a fixed-depth
// output pipeline. Optional PN9 mode is built when ADC_PN_SEQ_EN is
// defined; otherwise mode 6 falls back to midscale.
module adc_sample_pattern_gen
  import adc_sim_pkg::*;
#(
  parameter int PIPE_LATENCY = 10
)(
  input  logic        in_clk_p,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  test_mode,
  input  logic        out_format,
  input  logic [15:0] sample_in_a,
  input  logic [15:0] sample_in_b,
  output logic [13:0] data_a,
  output logic [13:0] data_b,
  output logic        ovr_a,
  output logic        ovr_b,
  output logic        valid
);

  logic [NUM_LANES-1:0][15:0] smp;
  assign smp = {sample_in_b, sample_in_a};

  // Per-lane saturation of the 16-bit stimulus into 14-bit range
  adc_word_t [NUM_LANES-1:0] sat_word;
  logic [NUM_LANES-1:0]      sat_ovr;

  // Clamp to -8192..8191 and flag the clamp
  always_comb begin
    sat_word = '0;
    sat_ovr  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ($signed(smp[i]) > 16'sd8191) begin
        sat_word[i] = POS_FS_TC;
        sat_ovr[i]  = 1'b1;
      end else if ($signed(smp[i]) < -16'sd8192) begin
        sat_word[i] = NEG_FS_TC;
        sat_ovr[i]  = 1'b1;
      end else begin
        sat_word[i] = smp[i][VEC_W-1:0];
      end
    end
  end

  // Pattern state. A mode change is seen combinationally so the new
  // mode's first word goes out on the very cycle it is selected.
  logic [3:0] last_mode;
  logic       entry;
  logic       phase, eff_phase;
  adc_word_t  ramp, eff_ramp;

  assign entry     = (test_mode != last_mode);
  assign eff_phase = entry ? 1'b0 : phase;
  assign eff_ramp  = entry ? '0 : ramp;

  // Generators restart on mode entry and step only on enabled slots
  always_ff @(posedge in_clk_p or posedge reset) begin
    if (reset) begin
      last_mode <= TM_NORMAL;
      phase     <= 1'b0;
      ramp      <= '0;
    end else begin
      last_mode <= test_mode;
      phase     <= eff_phase ^ enable;
      ramp      <= eff_ramp + {{(VEC_W-1){1'b0}}, enable};
    end
  end

`ifdef ADC_PN_SEQ_EN
  logic [8:0] lfsr_state, eff_lfsr;
  adc_word_t  pn_word;

  adc_pn9_lfsr u_lfsr (
    .clk     (in_clk_p),
    .reset   (reset),
    .advance (enable),
    .reseed  (entry),
    .state   (lfsr_state)
  );

  assign eff_lfsr = entry ? PN9_SEED : lfsr_state;
  assign pn_word  = {eff_lfsr, eff_lfsr[8:4]};
`endif

  // Stage-0 word selection; disabled slots carry midscale, ovr=0
  lane_pkt_t                 stg0;
  logic                      numeric;
  adc_word_t [NUM_LANES-1:0] tc_word;
  adc_word_t                 raw_word;

  // Choose numeric (format-dependent) or raw (format-agnostic) source
  always_comb begin
    stg0     = '0;
    numeric  = 1'b1;
    tc_word  = {NUM_LANES{MIDSCALE_TC}};
    raw_word = '0;
    if (enable) begin
      case (test_mode)
        TM_NORMAL: begin
          tc_word  = sat_word;
          stg0.ovr = sat_ovr;
        end
        TM_POS_FS:  tc_word = {NUM_LANES{POS_FS_TC}};
        TM_NEG_FS:  tc_word = {NUM_LANES{NEG_FS_TC}};
        TM_CHECKER: begin
          numeric  = 1'b0;
          raw_word = eff_phase ? CHECKER_B : CHECKER_A;
        end
        TM_TOGGLE: begin
          numeric  = 1'b0;
          raw_word = eff_phase ? '0 : TOGGLE_HI;
        end
`ifdef ADC_PN_SEQ_EN
        TM_PN9: begin
          numeric  = 1'b0;
          raw_word = pn_word;
        end
`endif
        TM_RAMP: begin
          numeric  = 1'b0;
          raw_word = eff_ramp;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_LANES; i++)
      stg0.data[i] = numeric ? (tc_word[i] ^ (out_format ? '0 : FMT_MSB)) : raw_word;
  end

  // Free-running delay line; reset flushes every stage
  lane_pkt_t                 pipe [1:PIPE_LATENCY];
  logic [PIPE_LATENCY:1]     vld_pipe;

  // Shift payload and valid one stage per clock
  always_ff @(posedge in_clk_p or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= PIPE_LATENCY; i++) pipe[i] <= '0;
      vld_pipe <= '0;
    end else begin
      pipe[1]     <= stg0;
      vld_pipe[1] <= enable;
      for (int i = 2; i <= PIPE_LATENCY; i++) begin
        pipe[i]     <= pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign data_a = pipe[PIPE_LATENCY].data[0];
  assign data_b = pipe[PIPE_LATENCY].data[1];
  assign ovr_a  = pipe[PIPE_LATENCY].ovr[0];
  assign ovr_b  = pipe[PIPE_LATENCY].ovr[1];
  assign valid  = vld_pipe[PIPE_LATENCY];

endmodule

// File: tb/tb_adc_sample_pattern_gen.sv
// Directed + scoreboard bench for adc_sample_pattern_gen.
module tb_adc_sample_pattern_gen;

  localparam int N = 10;

  logic               in_clk_p = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [3:0]         test_mode = 4'd0;
  logic               out_format = 1'b0;
  logic signed [15:0] sample_in_a = '0;
  logic signed [15:0] sample_in_b = '0;
  logic [13:0]        data_a, data_b;
  logic               ovr_a, ovr_b, valid;

  adc_sample_pattern_gen #(.PIPE_LATENCY(N)) dut (
    .in_clk_p    (in_clk_p),
    .reset       (reset),
    .enable      (enable),
    .test_mode   (test_mode),
    .out_format  (out_format),
    .sample_in_a (sample_in_a),
    .sample_in_b (sample_in_b),
    .data_a      (data_a),
    .data_b      (data_b),
    .ovr_a       (ovr_a),
    .ovr_b       (ovr_b),
    .valid       (valid)
  );

  always #5 in_clk_p = ~in_clk_p;

  typedef struct packed {
    logic [13:0] da;
    logic [13:0] db;
    logic        oa;
    logic        ob;
    logic        v;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    mode_q[$];
  int    idx_q[$];

  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  // reference model state: words emitted since the current mode began
  int         m_prev = 0;
  int         m_idx  = 0;
  logic [8:0] m_lfsr = 9'h1FF;

  function automatic obs_t get_obs();
    return {data_a, data_b, ovr_a, ovr_b, valid};
  endfunction

  task automatic chk(input string t, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  function automatic logic [13:0] m_sat(input logic signed [15:0] x, output logic o);
    o = 1'b0;
    if (x > 16'sd8191)       begin o = 1'b1; return 14'h1FFF; end
    else if (x < -16'sd8192) begin o = 1'b1; return 14'h2000; end
    else return x[13:0];
  endfunction

  task automatic model_push(input logic en, input logic [3:0] mode, input logic fmt,
                            input logic signed [15:0] a, input logic signed [15:0] b);
    obs_t e;
    logic [13:0] tca, tcb, raw;
    logic numeric, oa, ob;
    int   cur_idx;
    if (int'(mode) != m_prev) begin m_idx = 0; m_lfsr = 9'h1FF; end
    m_prev = int'(mode);
    e = '0; numeric = 1'b1; tca = '0; tcb = '0; raw = '0; oa = 1'b0; ob = 1'b0;
    cur_idx = m_idx;
    if (en) begin
      case (mode)
        4'd0: begin tca = m_sat(a, oa); tcb = m_sat(b, ob); end
        4'd2: begin tca = 14'h1FFF; tcb = 14'h1FFF; end
        4'd3: begin tca = 14'h2000; tcb = 14'h2000; end
        4'd4: begin numeric = 1'b0; raw = m_idx[0] ? 14'h1555 : 14'h2AAA; end
        4'd5: begin numeric = 1'b0; raw = m_idx[0] ? 14'h0000 : 14'h3FFF; end
        4'd6: begin
`ifdef ADC_PN_SEQ_EN
          numeric = 1'b0;
          raw = {m_lfsr, m_lfsr[8:4]};
`endif
        end
        4'd7: begin numeric = 1'b0; raw = m_idx[13:0]; end
        default: ;
      endcase
      m_idx++;
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    end
    if (numeric) begin
      e.da = fmt ? tca : (tca ^ 14'h2000);
      e.db = fmt ? tcb : (tcb ^ 14'h2000);
    end else begin
      e.da = raw;
      e.db = raw;
    end
    e.oa = oa;
    e.ob = ob;
    e.v  = en;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    mode_q.push_back(en ? int'(mode) : -1);
    idx_q.push_back(cur_idx);
  endtask

  // one clock: drive, predict, then compare whatever leaves the pipe
  task automatic cycle(input logic en, input logic [3:0] mode, input logic fmt,
                       input logic signed [15:0] a, input logic signed [15:0] b);
    obs_t  e, o;
    string t;
    int    md, ix;
    enable = en; test_mode = mode; out_format = fmt;
    sample_in_a = a; sample_in_b = b;
    model_push(en, mode, fmt, a, b);
    @(posedge in_clk_p); #1;
    o = get_obs();
    if (exp_q.size() >= N) begin
      e  = exp_q.pop_front();
      t  = tag_q.pop_front();
      md = mode_q.pop_front();
      ix = idx_q.pop_front();
      chk(t, o, e);
`ifdef ADC_PN_SEQ_EN
      if (md == 6 && (ix == 0 || ix == 511)) begin
        checks++;
        assert (data_a === 14'h3FFF) else begin
          errors++;
          $error("FAIL pn9_period idx=%0d observed=%h expected=3fff", ix, data_a);
        end
      end
`endif
      if (md == 7 && (ix == 16383 || ix == 16384)) begin
        checks++;
        assert (data_a === ((ix == 16383) ? 14'h3FFF : 14'h0000)) else begin
          errors++;
          $error("FAIL ramp_wrap idx=%0d observed=%h", ix, data_a);
        end
      end
    end else begin
      chk({tag, "_flushed"}, o, '0);
    end
    @(negedge in_clk_p);
  endtask

  task automatic flush_model();
    exp_q.delete(); tag_q.delete(); mode_q.delete(); idx_q.delete();
    m_prev = 0; m_idx = 0; m_lfsr = 9'h1FF;
  endtask

  initial begin
    logic [3:0] rm;
    // reset state
    repeat (2) @(posedge in_clk_p);
    #1 chk("reset_init", get_obs(), '0);
    @(negedge in_clk_p);
    reset = 1'b0;

    // normal mode: saturation and both formats
    tag = "normal";
    cycle(1, 0, 1,  16'sd20000, -16'sd100);
    cycle(1, 0, 1, -16'sd20000,  16'sd8191);
    cycle(1, 0, 0, -16'sd8192,   16'sd8192);
    cycle(1, 0, 0,  16'sd0,     -16'sd8193);
    cycle(1, 0, 1,  16'sd32767, -16'sd32768);
    cycle(0, 0, 1,  16'sd20000,  16'sd5);

    // fixed numeric levels
    tag = "levels";
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(1, 2, 1, 0, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(1, 3, 1, 0, 0);
    for (int m = 8; m < 16; m++) cycle(1, 4'(m), m[0], 16'sd1234, 16'sd77);

    // checkerboard, then toggle with enable 1,0,1
    tag = "checker";
    repeat (4) cycle(1, 4, 0, 0, 0);
    tag = "toggle";
    cycle(1, 5, 1, 0, 0);
    cycle(0, 5, 0, 0, 0);
    cycle(1, 5, 1, 0, 0);
    cycle(1, 5, 0, 0, 0);

    // PN9 over more than one full period
    tag = "pn9";
    repeat (520) cycle(1, 6, 1, 0, 0);
    cycle(0, 6, 0, 0, 0);
    cycle(1, 6, 0, 0, 0);

    // ramp across the 14-bit wrap
    tag = "ramp";
    repeat (16384 + 4) cycle(1, 7, 0, 0, 0);
    cycle(0, 7, 1, 0, 0);
    cycle(1, 7, 1, 0, 0);

    // random mix: mode changes land while older words are in flight
    tag = "random";
    rm = 4'd0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) rm = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 3) != 0), rm, 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
    end

    // mid-stream reset with words in flight
    tag = "prefill";
    repeat (N + 5) cycle(1, 2, 1, 0, 0);
    #2 reset = 1'b1;
    #1 chk("reset_async", get_obs(), '0);
    flush_model();
    @(posedge in_clk_p); #1 chk("reset_hold", get_obs(), '0);
    @(negedge in_clk_p);
    reset = 1'b0;
    tag = "post_reset";
    repeat (N + 3) cycle(1, 7, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
